// File: rtl/sata_oob_hostctl.sv
// Host-side SATA OOB link-initialisation sequencer: COMRESET/COMWAKE scheduling, detection
// monitoring, per-phase timeouts with bounded retries, and transmit-source selection.
module sata_oob_hostctl #(
  parameter int unsigned INIT_TIMEOUT  = 8192,
  parameter int unsigned WAKE_TIMEOUT  = 2048,
  parameter int unsigned ALIGN_TIMEOUT = 4096,
  parameter int unsigned ALIGN_HOLD    = 16,
  parameter int unsigned MAX_RETRIES   = 4
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_start,
  output logic       o_com_valid,
  output logic       o_com_wake,
  input  logic       i_com_ready,
  input  logic       i_com_done,
  input  logic       i_cominit_det,
  input  logic       i_comwake_det,
  input  logic       i_align_det,
  output logic [1:0] o_txsel,
  output logic       o_link_up,
  output logic       o_fail,
  output logic [3:0] o_retries
);

  localparam int unsigned MaxIw = (INIT_TIMEOUT > WAKE_TIMEOUT) ? INIT_TIMEOUT : WAKE_TIMEOUT;
  localparam int unsigned MaxIwa = (MaxIw > ALIGN_TIMEOUT) ? MaxIw : ALIGN_TIMEOUT;
  localparam int unsigned MaxTo = (MaxIwa > ALIGN_HOLD) ? MaxIwa : ALIGN_HOLD;
  localparam int unsigned CntW = $clog2(MaxTo) + 1;

  localparam logic [CntW-1:0] InitLast  = CntW'(INIT_TIMEOUT - 1);
  localparam logic [CntW-1:0] WakeLast  = CntW'(WAKE_TIMEOUT - 1);
  localparam logic [CntW-1:0] AlignLast = CntW'(ALIGN_TIMEOUT - 1);
  localparam logic [CntW-1:0] HoldLast  = CntW'(ALIGN_HOLD - 1);
  localparam logic [3:0]      RetryMax  = 4'(MAX_RETRIES);

  typedef enum logic [3:0] {
    StIdle, StSendReset, StResetBusy, StWaitInit, StWaitInitClr, StSendWake, StWakeBusy,
    StWaitWake, StWaitWakeClr, StWaitAlign, StSendAlign, StLinkUp, StRetry, StFail
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [3:0]      retries_q, retries_d;
  logic            com_valid_q, com_valid_d;
  logic            com_wake_q, com_wake_d;
  logic [1:0]      txsel_q, txsel_d;
  logic            link_up_q, link_up_d;
  logic            fail_q, fail_d;
  logic            accept;

  assign accept = com_valid_q && i_com_ready;

  always_comb begin
    state_d   = state_q;
    retries_d = retries_q;
    case (state_q)
      StIdle: begin
        if (i_start) begin
          state_d   = StSendReset;
          retries_d = '0;
        end
      end
      StSendReset:   if (accept) state_d = StResetBusy;
      StResetBusy:   if (i_com_done) state_d = StWaitInit;
      StWaitInit: begin
        if (i_cominit_det)         state_d = StWaitInitClr;
        else if (cnt_q == InitLast) state_d = StRetry;
      end
      StWaitInitClr: if (!i_cominit_det) state_d = StSendWake;
      StSendWake:    if (accept) state_d = StWakeBusy;
      StWakeBusy:    if (i_com_done) state_d = StWaitWake;
      StWaitWake: begin
        if (i_comwake_det)          state_d = StWaitWakeClr;
        else if (cnt_q == WakeLast) state_d = StRetry;
      end
      StWaitWakeClr: if (!i_comwake_det) state_d = StWaitAlign;
      StWaitAlign: begin
        if (i_align_det)             state_d = StSendAlign;
        else if (cnt_q == AlignLast) state_d = StRetry;
      end
      StSendAlign:   if (cnt_q == HoldLast) state_d = StLinkUp;
      StLinkUp:      state_d = StLinkUp;
      StRetry: begin
        retries_d = retries_q + 4'd1;
        state_d   = (retries_q + 4'd1 == RetryMax) ? StFail : StSendReset;
      end
      StFail: begin
        if (i_start) begin
          state_d   = StSendReset;
          retries_d = '0;
        end
      end
      default: state_d = StIdle;
    endcase

    // A device-initiated COMINIT after the handshake began restarts from the COMWAKE stage.
    if (i_cominit_det && (state_q inside {StWaitWake, StWaitWakeClr, StWaitAlign, StSendAlign,
                                          StLinkUp})) begin
      state_d = StWaitInitClr;
    end

    cnt_d = (state_d != state_q) ? '0 : cnt_q + CntW'(1);

    // Outputs are decoded from the next state so the registered copy matches the new state.
    com_valid_d = (state_d == StSendReset) || (state_d == StSendWake);
    com_wake_d  = (state_d == StSendWake);
    link_up_d   = (state_d == StLinkUp);
    fail_d      = (state_d == StFail);
    case (state_d)
      StWaitAlign: txsel_d = 2'd1;
      StSendAlign: txsel_d = 2'd2;
      StLinkUp:    txsel_d = 2'd3;
      default:     txsel_d = 2'd0;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      retries_q   <= '0;
      com_valid_q <= 1'b0;
      com_wake_q  <= 1'b0;
      txsel_q     <= 2'd0;
      link_up_q   <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retries_q   <= retries_d;
      com_valid_q <= com_valid_d;
      com_wake_q  <= com_wake_d;
      txsel_q     <= txsel_d;
      link_up_q   <= link_up_d;
      fail_q      <= fail_d;
    end
  end

  assign o_com_valid = com_valid_q;
  assign o_com_wake  = com_wake_q;
  assign o_txsel     = txsel_q;
  assign o_link_up   = link_up_q;
  assign o_fail      = fail_q;
  assign o_retries   = retries_q;

endmodule

// File: tb/tb_sata_oob_hostctl.sv
// Bench for sata_oob_hostctl: a device-side COM model driven by per-attempt response delays,
// a vector table of hand-derived outcomes, randomized scenarios and a few directed sequences.
`timescale 1ns/1ps
module tb_sata_oob_hostctl;
  localparam int unsigned InitTo  = 100;
  localparam int unsigned WakeTo  = 50;
  localparam int unsigned AlignTo = 80;
  localparam int unsigned Hold    = 4;
  localparam int unsigned MaxRet  = 3;
  localparam int          Budget  = 4000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       com_ready = 1'b0;
  logic       com_done = 1'b0;
  logic       cominit = 1'b0;
  logic       comwake = 1'b0;
  logic       align = 1'b0;
  logic       com_valid, com_wake, link_up, fail;
  logic [1:0] txsel;
  logic [3:0] retries;

  always #5 clk = ~clk;

  sata_oob_hostctl #(
    .INIT_TIMEOUT (InitTo),
    .WAKE_TIMEOUT (WakeTo),
    .ALIGN_TIMEOUT(AlignTo),
    .ALIGN_HOLD   (Hold),
    .MAX_RETRIES  (MaxRet)
  ) dut (
    .i_clk        (clk),
    .i_reset_n    (rst_n),
    .i_start      (start),
    .o_com_valid  (com_valid),
    .o_com_wake   (com_wake),
    .i_com_ready  (com_ready),
    .i_com_done   (com_done),
    .i_cominit_det(cominit),
    .i_comwake_det(comwake),
    .i_align_det  (align),
    .o_txsel      (txsel),
    .o_link_up    (link_up),
    .o_fail       (fail),
    .o_retries    (retries)
  );

  // Per-attempt device response delays (cycles after the relevant event); -1 means silent.
  typedef struct {
    int di0, dw0, da0, di1, dw1, da1, di2, dw2, da2;
    int stall;
    int link, fl, ret, nres, nwake;
  } vec_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int cur_di[3], cur_dw[3], cur_da[3];
  int stall_fix, n_reset, n_wake, n_txsel2, stab_err, reset_done_cyc;
  int busy, rdy_wait, ci_wait, ci_hold, cw_wait, cw_hold, al_wait;
  bit busy_wake, rdy_armed, acc_pend, acc_wake, al_armed, prev_valid, prev_wake;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic reset_dev();
    com_ready = 0; com_done = 0; cominit = 0; comwake = 0; align = 0; start = 0;
    n_reset = 0; n_wake = 0; n_txsel2 = 0; stab_err = 0; reset_done_cyc = 0;
    busy = 0; rdy_wait = 0; ci_wait = 0; ci_hold = 0; cw_wait = 0; cw_hold = 0; al_wait = -1;
    busy_wake = 0; rdy_armed = 0; acc_pend = 0; acc_wake = 0; al_armed = 0;
    prev_valid = 0; prev_wake = 0;
  endtask

  // Device side: reacts to what the host showed after the last edge, drives the next inputs.
  task automatic dev_step();
    int att;
    att = (n_reset > 0) ? n_reset - 1 : 0;
    if (att > 2) att = 2;
    com_done = 1'b0;
    if (ci_wait > 0) begin
      ci_wait--;
      if (ci_wait == 0) begin cominit = 1'b1; ci_hold = 1 + int'($urandom_range(0, 3)); end
    end else if (ci_hold > 0) begin
      ci_hold--;
      if (ci_hold == 0) cominit = 1'b0;
    end
    if (cw_wait > 0) begin
      cw_wait--;
      if (cw_wait == 0) begin comwake = 1'b1; cw_hold = 1 + int'($urandom_range(0, 3)); end
    end else if (cw_hold > 0) begin
      cw_hold--;
      if (cw_hold == 0) comwake = 1'b0;
    end
    if (acc_pend) begin
      acc_pend = 0;
      if (acc_wake) n_wake++; else n_reset++;
      busy = 2 + int'($urandom_range(0, 3));
      busy_wake = acc_wake;
    end else if (busy > 0) begin
      busy--;
      if (busy == 0) begin
        com_done = 1'b1;
        if (busy_wake) cw_wait = (cur_dw[att] >= 0) ? cur_dw[att] + 1 : 0;
        else begin
          reset_done_cyc = cyc;
          ci_wait = (cur_di[att] >= 0) ? cur_di[att] + 1 : 0;
        end
      end
    end
    if (txsel == 2'd0) al_armed = 0;
    else if (txsel == 2'd1 && !al_armed) begin al_armed = 1; al_wait = cur_da[att]; end
    align = 1'b0;
    if (al_armed && al_wait == 0 && (txsel == 2'd1 || txsel == 2'd2)) align = 1'b1;
    else if (al_armed && al_wait > 0) al_wait--;
    if (!com_valid) begin
      com_ready = 1'($urandom_range(0, 1));
      rdy_armed = 0;
    end else begin
      if (!rdy_armed) begin
        rdy_armed = 1;
        rdy_wait = (stall_fix >= 0) ? stall_fix : int'($urandom_range(0, 3));
      end
      if (rdy_wait == 0) com_ready = 1'b1;
      else begin com_ready = 1'b0; rdy_wait--; end
    end
    // A retried COMRESET after a silent init phase follows the timeout plus one retry cycle.
    if (com_valid && !prev_valid && !com_wake && n_reset > 0 && n_reset < int'(MaxRet) &&
        cur_di[att] < 0)
      check("reset_spacing", cyc - reset_done_cyc, int'(InitTo) + 2);
    if (com_valid && prev_valid && com_wake != prev_wake) stab_err++;
    if (txsel == 2'd2) n_txsel2++;
    acc_pend = com_valid && com_ready;
    acc_wake = com_wake;
    prev_valid = com_valid;
    prev_wake = com_wake;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    dev_step();
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_valid"}, int'(com_valid), 0);
    check({tag, "_wake"}, int'(com_wake), 0);
    check({tag, "_txsel"}, int'(txsel), 0);
    check({tag, "_link"}, int'(link_up), 0);
    check({tag, "_fail"}, int'(fail), 0);
    check({tag, "_retries"}, int'(retries), 0);
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (!link_up && !fail && n < Budget) begin tick(); n++; end
    if (n >= Budget) check({tag, "_budget"}, n, 0);
  endtask

  task automatic bring_up(input int stall, input string tag);
    rst_n = 1'b0;
    reset_dev();
    stall_fix = stall;
    #2;
    check_zero({tag, "_rst"});
    tick(); tick();
    rst_n = 1'b1;
    repeat (10) tick();
    check({tag, "_idle_valid"}, int'(com_valid), 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(tag);
    repeat (5) tick();
  endtask

  // Outcome from the retry rules alone: an attempt succeeds only if every phase responds in time.
  task automatic model(output int link, output int fl, output int ret, output int nres,
                       output int nwake);
    link = 0; fl = 0; ret = 0; nres = 0; nwake = 0;
    for (int a = 0; a < int'(MaxRet); a++) begin
      nres++;
      if (cur_di[a] >= 0 && cur_di[a] < int'(InitTo)) begin
        nwake++;
        if (cur_dw[a] >= 0 && cur_dw[a] < int'(WakeTo) && cur_da[a] >= 0 &&
            cur_da[a] < int'(AlignTo)) begin
          link = 1;
          return;
        end
      end
      ret++;
    end
    fl = 1;
  endtask

  task automatic compare(input string tag, input int link, input int fl, input int ret,
                         input int nres, input int nwake);
    check({tag, "_link"}, int'(link_up), link);
    check({tag, "_fail"}, int'(fail), fl);
    check({tag, "_retries"}, int'(retries), ret);
    check({tag, "_txsel"}, int'(txsel), link ? 3 : 0);
    check({tag, "_nreset"}, n_reset, nres);
    check({tag, "_nwake"}, n_wake, nwake);
    check({tag, "_align_cycles"}, n_txsel2, link ? int'(Hold) : 0);
    check({tag, "_stable"}, stab_err, 0);
  endtask

  function automatic int rnd_delay(input int unsigned to);
    return ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, to - 2));
  endfunction

  vec_t vecs[8];

  initial begin
    int link, fl, ret, nres, nwake, bad, n;
    vecs[0] = '{5, 10, 3, -1, -1, -1, -1, -1, -1, -1, 1, 0, 0, 1, 1};
    vecs[1] = '{-1, -1, -1, -1, -1, -1, -1, -1, -1, -1, 0, 1, 3, 3, 0};
    vecs[2] = '{5, 10, 3, -1, -1, -1, -1, -1, -1, 120, 1, 0, 0, 1, 1};
    vecs[3] = '{5, WakeTo - 2, 3, -1, -1, -1, -1, -1, -1, -1, 1, 0, 0, 1, 1};
    vecs[4] = '{5, WakeTo, 3, 5, 10, 3, -1, -1, -1, -1, 1, 0, 1, 2, 2};
    vecs[5] = '{5, 10, -1, 5, 10, -1, 5, 10, -1, -1, 0, 1, 3, 3, 3};
    vecs[6] = '{-1, -1, -1, 7, -1, -1, 0, 0, 0, -1, 1, 0, 2, 3, 2};
    vecs[7] = '{InitTo - 2, WakeTo - 2, AlignTo - 2, -1, -1, -1, -1, -1, -1, -1, 1, 0, 0, 1, 1};
    reset_dev();
    stall_fix = -1;

    for (int i = 0; i < 8; i++) begin
      cur_di = '{vecs[i].di0, vecs[i].di1, vecs[i].di2};
      cur_dw = '{vecs[i].dw0, vecs[i].dw1, vecs[i].dw2};
      cur_da = '{vecs[i].da0, vecs[i].da1, vecs[i].da2};
      bring_up(vecs[i].stall, $sformatf("vec%0d", i));
      compare($sformatf("vec%0d", i), vecs[i].link, vecs[i].fl, vecs[i].ret, vecs[i].nres,
              vecs[i].nwake);
      if (vecs[i].fl != 0) begin
        bad = 0;
        repeat (30) begin tick(); if (com_valid) bad++; end
        check($sformatf("vec%0d_quiet_after_fail", i), bad, 0);
      end
    end

    // Restart from FAIL.
    cur_di = '{-1, -1, -1}; cur_dw = '{-1, -1, -1}; cur_da = '{-1, -1, -1};
    bring_up(-1, "refail");
    check("refail_fail", int'(fail), 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("restart_fail_clr", int'(fail), 0);
    check("restart_valid", int'(com_valid), 1);
    check("restart_wake", int'(com_wake), 0);
    check("restart_retries", int'(retries), 0);

    // Unsolicited COMINIT once the link is up; i_start is ignored there.
    cur_di = '{5, -1, -1}; cur_dw = '{10, -1, -1}; cur_da = '{3, -1, -1};
    bring_up(-1, "unsol");
    check("unsol_up", int'(link_up), 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_ignored_link", int'(link_up), 1);
    check("start_ignored_valid", int'(com_valid), 0);
    cominit = 1'b1;
    tick();
    check("unsol_drop", int'(link_up), 0);
    check("unsol_txsel", int'(txsel), 0);
    tick(); tick();
    cominit = 1'b0;
    tick();
    wait_done("unsol_relink");
    repeat (3) tick();
    check("unsol_relink_up", int'(link_up), 1);
    check("unsol_retries", int'(retries), 0);
    check("unsol_nreset", n_reset, 1);
    check("unsol_nwake", n_wake, 2);
    check("unsol_align_cycles", n_txsel2, 2 * int'(Hold));

    // Asynchronous reset while the COMWAKE burst is in flight.
    cur_di = '{-1, 5, -1}; cur_dw = '{-1, 10, -1}; cur_da = '{-1, 3, -1};
    rst_n = 1'b0;
    reset_dev();
    stall_fix = -1;
    tick();
    rst_n = 1'b1;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (n_wake == 0 && n < Budget) begin tick(); n++; end
    check("midrst_reached_wake", n_wake, 1);
    check("midrst_retries_before", int'(retries), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("midrst");
    reset_dev();
    tick();
    rst_n = 1'b1;
    bad = 0;
    repeat (20) begin tick(); if (com_valid || txsel != 2'd0 || link_up || fail) bad++; end
    check("midrst_stays_idle", bad, 0);

    // Randomized delays against the retry-rule model.
    for (int r = 0; r < 12; r++) begin
      for (int a = 0; a < 3; a++) begin
        cur_di[a] = rnd_delay(InitTo);
        cur_dw[a] = rnd_delay(WakeTo);
        cur_da[a] = rnd_delay(AlignTo);
      end
      model(link, fl, ret, nres, nwake);
      bring_up(-1, $sformatf("rnd%0d", r));
      compare($sformatf("rnd%0d", r), link, fl, ret, nres, nwake);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
